// File: rtl/integ_sample_sequencer_if.sv
// Upstream sample handshake bundle for integ_sample_sequencer.
// Signals: s_valid/s_data (source to sequencer), s_ready (sequencer to source).
interface integ_sample_sequencer_if #(
    parameter int N = 64
) ();
    logic         s_valid;
    logic [N-1:0] s_data;
    logic         s_ready;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/integ_sample_sequencer.sv
// Sample FIFO + window sequencer feeding the integrator.
// Ports: clk, resetb (async low); smp (slave: s_valid/s_data/s_ready);
//   cmd_start/cmd_len window command; busy, done status;
//   signal_input/start_integration registered sample stream; fifo_level.
// Option: define SEQ_ZERO_FILL_EN to emit zeros instead of stalling.
module integ_sample_sequencer #(
    parameter int N     = 64,
    parameter int DEPTH = 8,
    parameter int LEN_W = 16
) (
    input  logic                     clk,
    input  logic                     resetb,
    integ_sample_sequencer_if.slave  smp,
    input  logic                     cmd_start,
    input  logic [LEN_W-1:0]         cmd_len,
    output logic                     busy,
    output logic [N-1:0]             signal_input,
    output logic                     start_integration,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] rem_d;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count_q;
    logic [N-1:0]     mem [DEPTH];
    logic             push;
    logic             pop;
    logic             emit;
    logic             full;
    logic             empty;

    assign full        = (count_q == LW'(DEPTH));
    assign empty       = (count_q == '0);
    assign smp.s_ready = !full;
    assign push        = smp.s_valid && !full;
    assign fifo_level  = count_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

    // RUN stays one extra cycle after the last emit (remaining == 0) so
    // that done lands the cycle after the last qualified sample.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        emit    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    rem_d   = cmd_len;
                    state_d = (cmd_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (rem_q == '0) begin
                    state_d = DONE;
                end else begin
                    pop = !empty;
`ifdef SEQ_ZERO_FILL_EN
                    emit = 1'b1;
`else
                    emit = !empty;
`endif
                    if (emit) begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_q + LW'(push) - LW'(pop);
        end
    end

    // Storage needs no reset; occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= smp.s_data;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            signal_input      <= '0;
            start_integration <= 1'b0;
        end else begin
            start_integration <= emit;
            if (pop) begin
                signal_input <= mem[rd_ptr];
            end
`ifdef SEQ_ZERO_FILL_EN
            else if (emit) begin
                signal_input <= '0;
            end
`endif
        end
    end
endmodule
